// File: rtl/lock_clear.sv
// lock_clear: writes a locked tetromino into the board RAM, then scans the
// board bottom-up, removes every full row by shifting the rows above it down
// one row at a time, and zero-fills row 0 after each removal.
// Optional build macro: LOCK_CLEAR_SCORE_EN adds a saturating 16-bit score
// that accumulates 0/40/100/300/1200 points per operation.

// Piece shape table: four cells per piece, 2-bit offsets packed cell-major.
// rot[0] transposes the shape, rot[1] mirrors the column offsets.
module lut (
    input  logic [3:0] block,
    input  logic [1:0] rot,
    output logic [7:0] coord_x,
    output logic [7:0] coord_y,
    output logic [5:0] colour
);
    logic [7:0] base_x;
    logic [7:0] base_y;
    logic [7:0] sw_x;
    logic [7:0] sw_y;

    // Base shapes (rotation 0); ids 7..15 are unused and render as nothing.
    always_comb begin
        base_x = 8'h00;
        base_y = 8'h00;
        colour = 6'd0;
        unique case (block)
            4'd0: begin base_x = 8'b00_00_00_00; base_y = 8'b11_10_01_00; colour = 6'd1; end // I (vertical)
            4'd1: begin base_x = 8'b01_00_01_00; base_y = 8'b01_01_00_00; colour = 6'd2; end // O
            4'd2: begin base_x = 8'b01_10_01_00; base_y = 8'b01_00_00_00; colour = 6'd3; end // T
            4'd3: begin base_x = 8'b01_00_10_01; base_y = 8'b01_01_00_00; colour = 6'd4; end // S
            4'd4: begin base_x = 8'b10_01_01_00; base_y = 8'b01_01_00_00; colour = 6'd5; end // Z
            4'd5: begin base_x = 8'b01_00_01_01; base_y = 8'b10_10_01_00; colour = 6'd6; end // J
            4'd6: begin base_x = 8'b01_00_00_00; base_y = 8'b10_10_01_00; colour = 6'd7; end // L
            default: begin base_x = 8'h00; base_y = 8'h00; colour = 6'd0; end
        endcase
    end

    // Orientation: transpose, then optional column mirror (3 - cx == ~cx).
    always_comb begin
        sw_x    = rot[0] ? base_y : base_x;
        sw_y    = rot[0] ? base_x : base_y;
        coord_x = rot[1] ? ~sw_x : sw_x;
        coord_y = sw_y;
    end
endmodule

module lock_clear (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  X_anchor,
    input  logic [5:0]  Y_anchor,
    input  logic [3:0]  block,
    input  logic [5:0]  ram_Q,
    output logic [7:0]  ram_addr,
    output logic [5:0]  ram_D,
    output logic        ram_wren,
    output logic        busy,
    output logic        done,
    output logic [2:0]  lines_cleared,
    output logic [15:0] score
);
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_SCAN, S_SHIFT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  x_q, x_d;
    logic [5:0]  y_q, y_d;
    logic [3:0]  blk_q, blk_d;
    logic [1:0]  cell_q, cell_d;     // piece cell being written
    logic [4:0]  row_q, row_d;       // row under scan
    logic [4:0]  dst_q, dst_d;       // destination row during shift
    logic [3:0]  col_q, col_d;       // column / scan step (0..10)
    logic        rd_done_q, rd_done_d; // shift: read issued, next cycle writes
    logic        zero_q, zero_d;     // shift: zero-filling row 0
    logic        full_q, full_d;     // all samples so far in this row nonzero
    logic [2:0]  lines_q, lines_d;

    logic [7:0]  coord_x;
    logic [7:0]  coord_y;
    logic [5:0]  colour;
    logic [1:0]  cx;
    logic [1:0]  cy;
    logic [6:0]  cell_row;
    logic [5:0]  cell_col;
    logic        cell_ok;
    logic [7:0]  cell_addr;

    lut u_lut (
        .block   (blk_q),
        .rot     (2'b00),
        .coord_x (coord_x),
        .coord_y (coord_y),
        .colour  (colour)
    );

    function automatic logic [7:0] rc_addr(input logic [4:0] r, input logic [3:0] c);
        rc_addr = ({3'b000, r} * 8'd10) + {4'b0000, c};
    endfunction

    // Board coordinates of the current piece cell; out-of-board cells are not written.
    always_comb begin
        cx        = coord_x[{cell_q, 1'b0} +: 2];
        cy        = coord_y[{cell_q, 1'b0} +: 2];
        cell_row  = {1'b0, y_q} + {5'b00000, cy};
        cell_col  = {1'b0, x_q} + {4'b0000, cx};
        cell_ok   = (cell_row <= 7'd23) && (cell_col <= 6'd9);
        cell_addr = ({3'b000, cell_row[4:0]} * 8'd10) + {2'b00, cell_col};
    end

    // Next-state and RAM-port logic for the lock/scan/shift sequence.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        blk_d     = blk_q;
        cell_d    = cell_q;
        row_d     = row_q;
        dst_d     = dst_q;
        col_d     = col_q;
        rd_done_d = rd_done_q;
        zero_d    = zero_q;
        full_d    = full_q;
        lines_d   = lines_q;
        ram_addr  = 8'd0;
        ram_D     = 6'd0;
        ram_wren  = 1'b0;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = X_anchor;
                    y_d     = Y_anchor;
                    blk_d   = block;
                    lines_d = 3'd0;
                    cell_d  = 2'd0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                ram_addr = cell_addr;
                ram_D    = colour;
                ram_wren = cell_ok;
                cell_d   = cell_q + 2'd1;
                if (cell_q == 2'd3) begin
                    state_d = S_SCAN;
                    row_d   = 5'd23;
                    col_d   = 4'd0;
                end
            end
            S_SCAN: begin
                // Step k presents column k; ram_Q in step k holds column k-1.
                ram_addr = rc_addr(row_q, (col_q > 4'd9) ? 4'd9 : col_q);
                full_d   = (col_q == 4'd0) ? 1'b1 : (full_q && (ram_Q != 6'd0));
                col_d    = col_q + 4'd1;
                if (col_q == 4'd10) begin
                    col_d = 4'd0;
                    if (full_q && (ram_Q != 6'd0)) begin
                        state_d   = S_SHIFT;
                        dst_d     = row_q;
                        rd_done_d = 1'b0;
                        zero_d    = (row_q == 5'd0);
                    end else if (row_q != 5'd0) begin
                        row_d = row_q - 5'd1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                if (zero_q) begin
                    ram_addr = rc_addr(5'd0, col_q);
                    ram_wren = 1'b1;
                    col_d    = col_q + 4'd1;
                    if (col_q == 4'd9) begin
                        col_d   = 4'd0;
                        zero_d  = 1'b0;
                        lines_d = lines_q + 3'd1;
                        state_d = S_SCAN;
                    end
                end else if (!rd_done_q) begin
                    ram_addr  = rc_addr(dst_q - 5'd1, col_q);
                    rd_done_d = 1'b1;
                end else begin
                    ram_addr  = rc_addr(dst_q, col_q);
                    ram_D     = ram_Q;
                    ram_wren  = 1'b1;
                    rd_done_d = 1'b0;
                    col_d     = col_q + 4'd1;
                    if (col_q == 4'd9) begin
                        col_d = 4'd0;
                        dst_d = dst_q - 5'd1;
                        if (dst_q == 5'd1) begin
                            zero_d = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            x_q       <= 5'd0;
            y_q       <= 6'd0;
            blk_q     <= 4'd0;
            cell_q    <= 2'd0;
            row_q     <= 5'd0;
            dst_q     <= 5'd0;
            col_q     <= 4'd0;
            rd_done_q <= 1'b0;
            zero_q    <= 1'b0;
            full_q    <= 1'b0;
            lines_q   <= 3'd0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            blk_q     <= blk_d;
            cell_q    <= cell_d;
            row_q     <= row_d;
            dst_q     <= dst_d;
            col_q     <= col_d;
            rd_done_q <= rd_done_d;
            zero_q    <= zero_d;
            full_q    <= full_d;
            lines_q   <= lines_d;
        end
    end

    assign lines_cleared = lines_q;

`ifdef LOCK_CLEAR_SCORE_EN
    logic [15:0] score_q, score_d;
    logic [10:0] points;
    logic [16:0] score_sum;

    // Score update on the DONE cycle, saturating at all-ones.
    always_comb begin
        unique case (lines_q)
            3'd1:    points = 11'd40;
            3'd2:    points = 11'd100;
            3'd3:    points = 11'd300;
            3'd4:    points = 11'd1200;
            default: points = 11'd0;
        endcase
        score_sum = {1'b0, score_q} + {6'b000000, points};
        score_d   = score_q;
        if (state_q == S_DONE) begin
            score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
    end

    // Score register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_q <= 16'd0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;
`else
    assign score = 16'h0000;
`endif
endmodule

// File: tb/tb_lock_clear.sv
// Bench for lock_clear: a 1-cycle-latency board RAM model, a table of lock
// operations with hand-computed expectations, and hand-written sequences for
// reset state and reset during a row shift.
module tb_lock_clear;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  X_anchor;
    logic [5:0]  Y_anchor;
    logic [3:0]  block;
    logic [5:0]  ram_Q;
    logic [7:0]  ram_addr;
    logic [5:0]  ram_D;
    logic        ram_wren;
    logic        busy;
    logic        done;
    logic [2:0]  lines_cleared;
    logic [15:0] score;

    lock_clear dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .X_anchor      (X_anchor),
        .Y_anchor      (Y_anchor),
        .block         (block),
        .ram_Q         (ram_Q),
        .ram_addr      (ram_addr),
        .ram_D         (ram_D),
        .ram_wren      (ram_wren),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .score         (score)
    );

    always #5 clk = ~clk;

    // Board RAM: synchronous read, one cycle latency; bulk load for setup.
    logic [5:0] mem [0:255];
    logic [5:0] img [0:255];
    logic [5:0] mdl [0:255];
    logic       load_en = 1'b0;

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (ram_wren) begin
            mem[ram_addr] <= ram_D;
        end
        ram_Q <= mem[ram_addr];
    end

    typedef struct {
        int pat;        // board preset
        int x;
        int y;
        int blk;        // 0 = I (vertical), 1 = O
        int colour;
        int exp_wr;     // writes during the 4 lock cycles
        int exp_lines;
        int exp_cyc;    // cycle of the done pulse, 0 = not checked
        int busy_start; // cycle at which a stray start is pulsed, 0 = none
    } vec_t;

    vec_t vt [8];
    int n_chk = 0;
    int n_fail = 0;
    int exp_score = 0;
    int pts [5] = '{0, 40, 100, 300, 1200};

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_cell(input int r, input int c, input int v);
        img[r*10 + c] = 6'(v);
    endtask

    // Board presets.
    task automatic build_pattern(input int pat);
        for (int i = 0; i < 256; i++) img[i] = 6'd0;
        case (pat)
            1: begin // row 23 missing cols 6,7; marker above
                for (int c = 0; c < 10; c++) if (c < 6 || c > 7) set_cell(23, c, 10 + c);
                set_cell(22, 0, 40);
            end
            2: begin // rows 20..23 missing col 0; markers above
                for (int r = 20; r < 24; r++) for (int c = 1; c < 10; c++) set_cell(r, c, 20 + c);
                set_cell(19, 5, 33);
                set_cell(18, 2, 34);
            end
            3: begin // row 0 missing col 9
                for (int c = 0; c < 9; c++) set_cell(0, c, 50 + c);
                set_cell(7, 4, 35);
            end
            4: begin // rows 21..23 missing col 9
                for (int r = 21; r < 24; r++) for (int c = 0; c < 9; c++) set_cell(r, c, r + c);
                set_cell(20, 1, 36);
            end
            default: ;
        endcase
        for (int i = 0; i < 256; i++) mdl[i] = img[i];
    endtask

    // Expected board: place the piece, then remove full rows bottom-up.
    task automatic model_op(input vec_t v);
        int r, cx, cy;
        bit full;
        for (int i = 0; i < 4; i++) begin
            cx = (v.blk == 0) ? 0 : (i % 2);
            cy = (v.blk == 0) ? i : (i / 2);
            if (v.y + cy <= 23 && v.x + cx <= 9) mdl[(v.y + cy)*10 + v.x + cx] = 6'(v.colour);
        end
        r = 23;
        while (r >= 0) begin
            full = 1'b1;
            for (int c = 0; c < 10; c++) if (mdl[r*10 + c] == 6'd0) full = 1'b0;
            if (full) begin
                for (int d = r; d > 0; d--) for (int c = 0; c < 10; c++) mdl[d*10 + c] = mdl[(d-1)*10 + c];
                for (int c = 0; c < 10; c++) mdl[c] = 6'd0;
            end else begin
                r--;
            end
        end
    endtask

    task automatic load_board();
        @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cnt, wcnt, dcnt, cyc, wrap, bad, first_bad, early_idle;
        build_pattern(v.pat);
        model_op(v);
        load_board();
        X_anchor = 5'(v.x);
        Y_anchor = 6'(v.y);
        block    = 4'(v.blk);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0; wcnt = 0; dcnt = 0; cyc = 0; wrap = 0; early_idle = 0;
        while (cnt < 20000) begin
            cnt++;
            if (ram_wren && cnt <= 4) wcnt++;
            if (ram_wren && ram_addr >= 8'd240) wrap++;
            if (done) begin
                dcnt++;
                if (cyc == 0) cyc = cnt;
            end
            if (!busy) begin
                if (dcnt == 0) early_idle = 1;
                break;
            end
            if (v.busy_start != 0 && cnt == v.busy_start) begin
                start = 1'b1; X_anchor = 5'd0; Y_anchor = 6'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk($sformatf("v%0d timeout", idx), (cnt >= 20000) ? 1 : 0, 0);
        chk($sformatf("v%0d idle_before_done", idx), early_idle, 0);
        chk($sformatf("v%0d lock_writes", idx), wcnt, v.exp_wr);
        chk($sformatf("v%0d done_pulses", idx), dcnt, 1);
        chk($sformatf("v%0d high_addr_writes", idx), wrap, 0);
        chk($sformatf("v%0d lines_cleared", idx), int'(lines_cleared), v.exp_lines);
        if (v.exp_cyc != 0) chk($sformatf("v%0d done_cycle", idx), cyc, v.exp_cyc);
        bad = 0; first_bad = -1;
        for (int i = 0; i < 240; i++) if (mem[i] !== mdl[i]) begin
            bad++;
            if (first_bad < 0) first_bad = i;
        end
        chk($sformatf("v%0d board_bad_cells(first=%0d)", idx, first_bad), bad, 0);
`ifdef LOCK_CLEAR_SCORE_EN
        exp_score += pts[v.exp_lines];
`endif
        chk($sformatf("v%0d score", idx), int'(score), exp_score);
        $display("vector %0d: X=%0d Y=%0d blk=%0d writes=%0d lines=%0d done_cycle=%0d score=%0d",
                 idx, v.x, v.y, v.blk, wcnt, lines_cleared, cyc, score);
    endtask

    initial begin
        int cnt;
        reset = 1'b1; start = 1'b0; X_anchor = 5'd0; Y_anchor = 6'd0; block = 4'd0;
        // A lock with no clears takes 4 write + 24*11 scan cycles; done is the next cycle.
        vt[0] = '{0, 4, 0,  1, 2, 4, 0, 4 + 24*11 + 1, 0};
        vt[1] = '{1, 6, 22, 1, 2, 4, 1, 0, 0};
        vt[2] = '{2, 0, 20, 0, 1, 4, 4, 0, 0};
        vt[3] = '{0, 0, 21, 0, 1, 3, 0, 4 + 24*11 + 1, 0};
        vt[4] = '{0, 9, 5,  1, 2, 2, 0, 4 + 24*11 + 1, 0};
        vt[5] = '{3, 9, 0,  0, 1, 4, 1, 0, 0};
        vt[6] = '{4, 9, 20, 0, 1, 4, 3, 0, 0};
        vt[7] = '{0, 2, 10, 1, 2, 4, 0, 4 + 24*11 + 1, 30};

        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset wren", int'(ram_wren), 0);
        chk("reset done", int'(done), 0);
        chk("reset addr", int'(ram_addr), 0);
        chk("reset lines", int'(lines_cleared), 0);
        chk("reset score", int'(score), 0);
        reset = 1'b0;
        $display("reset released: busy=%0d addr=%0d score=%0d", busy, ram_addr, score);

        for (int i = 0; i < 8; i++) run_vec(i, vt[i]);

        // Reset while the row shift is writing: outputs drop without a clock edge.
        build_pattern(1);
        load_board();
        X_anchor = 5'd6; Y_anchor = 6'd22; block = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (cnt < 2000 && !(cnt > 4 && ram_wren)) begin
            @(negedge clk);
            cnt++;
        end
        chk("shift write reached", (cnt < 2000) ? 1 : 0, 1);
        reset = 1'b1;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort wren", int'(ram_wren), 0);
        chk("abort addr", int'(ram_addr), 0);
        chk("abort data", int'(ram_D), 0);
        chk("abort lines", int'(lines_cleared), 0);
        chk("abort score", int'(score), 0);
        $display("reset during shift at cycle %0d: busy=%0d wren=%0d", cnt, busy, ram_wren);
        exp_score = 0;
        @(negedge clk);
        reset = 1'b0;
        run_vec(8, vt[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lock_clear.md
LOCK_CLEAR -- requirements
Module: lock_clear

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port start  input  1  one-cycle request to lock the current piece; sampled only in IDLE.
REQ-004 SHALL have port X_anchor  input  5  piece anchor column, 0..9.
REQ-005 SHALL have port Y_anchor  input  6  piece anchor row, 0..23.
REQ-006 SHALL have port block  input  4  tetromino id, passed to the team lut module.
REQ-007 SHALL have port ram_Q  input  6  board RAM read data; 0 = empty cell.
REQ-008 SHALL have port ram_addr  output  8  board RAM address = row*10 + col.
REQ-009 SHALL have port ram_D  output  6  board RAM write data.
REQ-010 SHALL have port ram_wren  output  1  board RAM write enable.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse at end of operation.
REQ-013 SHALL have port lines_cleared  output  3  rows removed by last operation, 0..4.
REQ-014 SHALL have port score  output  16  accumulated score (see Configuration).

Function
REQ-015 SHALL instantiate lut(block, 2'b00, coord_x, coord_y, colour); cell i offsets are coord_x[2i+1:2i] and coord_y[2i+1:2i].
REQ-016 SHALL assume synchronous RAM with 1-cycle read latency: ram_Q reflects the address presented in the previous cycle.
REQ-017 SHALL implement FSM IDLE -> WRITE -> SCAN -> (SHIFT -> SCAN)* -> DONE -> IDLE.
REQ-018 IDLE: on start=1, latch X_anchor, Y_anchor and block, clear lines_cleared, enter WRITE; start in any other state SHALL be ignored.
REQ-019 WRITE: 4 cycles, cell i=0..3; ram_addr=(Y+cy_i)*10+X+cx_i, ram_D=colour, ram_wren=1.
REQ-020 WRITE: for a cell with row>23 or col>9, ram_wren SHALL be 0 for that cycle (write suppressed, no wrap).
REQ-021 SCAN: row pointer r starts at 23; present cols 0..9 of row r on consecutive cycles, sample ram_Q one cycle later; 11 cycles per row.
REQ-022 SCAN: the row is full iff all 10 samples are nonzero; full -> SHIFT with d=r; not full and r>0 -> r=r-1, rescan; not full and r=0 -> DONE.
REQ-023 SHIFT: for d from r down to 1, for col 0..9: one cycle to read (d-1,col), next cycle write the sampled ram_Q to (d,col); 2 cycles per cell.
REQ-024 SHIFT: row 0 SHALL then be written with 0, 1 cycle per cell; then lines_cleared += 1 and return to SCAN of the same r (no decrement).
REQ-025 SHIFT of row r=0: only the row-0 zero-fill SHALL occur.
REQ-026 ram_wren SHALL be 0 in IDLE, SCAN and DONE, and during SHIFT read cycles.
REQ-027 DONE: assert done for exactly 1 cycle, then return to IDLE; lines_cleared SHALL hold until the next accepted start.
REQ-028 Address arithmetic SHALL be at least 8 bits wide with no truncation for in-range coordinates (max 239).

Reset
REQ-029 reset=1 SHALL immediately force state IDLE and set ram_wren=0, busy=0, done=0, lines_cleared=0, score=0, ram_addr=0, ram_D=0, independent of clk.
REQ-030 Reset during WRITE or SHIFT SHALL abort the operation; partial board contents are not repaired.

Configuration
REQ-031 Macro LOCK_CLEAR_SCORE_EN defined: in DONE, add 0/40/100/300/1200 to score for lines_cleared 0/1/2/3/4; saturate at 16'hFFFF.
REQ-032 Macro LOCK_CLEAR_SCORE_EN undefined: score SHALL be tied to 16'h0000 and no score logic synthesised.

Verification
REQ-033 Empty board, start with X=4, Y=0, O-piece -> exactly 4 writes to the piece cells, 24 row scans, done after 4+24*11 cycles, lines_cleared=0.
REQ-034 Row 23 cols 0..5 and 8..9 filled, piece fills (23,6),(23,7) -> row 23 cleared, rows shifted down, row 0 zeroed, lines_cleared=1, score +40 with macro.
REQ-035 Rows 20..23 full except col 0, I-piece vertical at col 0 -> lines_cleared=4, rows 0..3 zero, score +1200 with macro, 0 without.
REQ-036 Piece with one cell at row 24 -> only 3 writes (ram_wren low for that cell), no address wrap.
REQ-037 Assert reset mid-SHIFT -> busy=0, ram_wren=0 in the same cycle; next start accepted normally.
REQ-038 start pulsed while busy -> ignored; exactly one done pulse per accepted start.
